// File: rtl/fp_sub_arbiter.sv
// Round-robin arbiter sharing one combinational IEEE-754 subtractor across NUM_REQ requesters.
// Two-stage pipeline (operands, response). Define FP_SUB_ARB_PERF_EN to add perf counters.

module IEEE_754_subtractor (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        valid
);
    logic        big_s, sml_s, rnd, uf, nan_in;
    logic [7:0]  big_e, sml_e, shamt;
    logic [27:0] big_m, sml_m, sml_sh, raw;
    logic [26:0] nrm;
    logic [4:0]  lz;
    logic [9:0]  er;
    logic [30:0] mag;

    always_comb begin
        // b's sign is flipped so the whole operation becomes a + (-b), ordered by magnitude
        if (a[30:0] >= b[30:0]) begin
            big_s = a[31];  big_e = a[30:23]; big_m = {1'b0, a[30:23] != 8'd0, a[22:0], 3'b000};
            sml_s = ~b[31]; sml_e = b[30:23]; sml_m = {1'b0, b[30:23] != 8'd0, b[22:0], 3'b000};
        end else begin
            big_s = ~b[31]; big_e = b[30:23]; big_m = {1'b0, b[30:23] != 8'd0, b[22:0], 3'b000};
            sml_s = a[31];  sml_e = a[30:23]; sml_m = {1'b0, a[30:23] != 8'd0, a[22:0], 3'b000};
        end
        if (big_e == 8'd0) big_m = '0;
        if (sml_e == 8'd0) sml_m = '0;
        shamt = big_e - sml_e;
        if (shamt > 8'd26)
            sml_sh = {27'd0, |sml_m};
        else
            sml_sh = (sml_m >> shamt) | {27'd0, |(sml_m & ((28'd1 << shamt) - 28'd1))};
        raw = (big_s == sml_s) ? big_m + sml_sh : big_m - sml_sh;
        er  = {2'b00, big_e};
        lz  = '0;
        uf  = 1'b0;
        if (raw[27]) begin
            nrm = {raw[27:2], raw[1] | raw[0]};
            er  = er + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++)
                if (raw[i]) lz = 5'(26 - i);
            nrm = raw[26:0] << lz;
            er  = er - {5'd0, lz};
            uf  = (raw[26:0] == 27'd0) || (big_e <= {3'd0, lz});
        end
        // round to nearest even; the hidden bit carries into the exponent field
        rnd = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        mag = {er[7:0] - 8'd1, 23'd0} + {7'd0, nrm[26:3]} + {30'd0, rnd};
        nan_in = (a[30:23] == 8'hFF) | (b[30:23] == 8'hFF);
        valid  = 1'b1;
        if (nan_in) begin
            result = 32'h7FC0_0000;
            valid  = 1'b0;
        end else if (uf) begin
            result = 32'd0;
        end else if (er >= 10'd255 || mag[30:23] == 8'hFF) begin
            result = {big_s, 8'hFF, 23'd0};
            valid  = 1'b0;
        end else begin
            result = {big_s, mag};
        end
    end
endmodule

module fp_sub_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [32*NUM_REQ-1:0]      req_a,
    input  logic [32*NUM_REQ-1:0]      req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [31:0]                rsp_result,
    output logic                       rsp_flag,
    output logic                       busy
`ifdef FP_SUB_ARB_PERF_EN
    ,
    output logic [31:0]                perf_busy,
    output logic [31:0]                perf_stall
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

    logic [31:0]        op_a [NUM_REQ];
    logic [31:0]        op_b [NUM_REQ];
    logic               s1_valid, s2_load, s1_free, hs, found, sub_vld;
    logic [31:0]        s1_a, s1_b, sub_res;
    logic [ID_W-1:0]    s1_id, last_grant, gidx, idx;
    logic [ID_W:0]      sum_idx;
    logic [NUM_REQ-1:0] grant;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g] = req_a[32*g +: 32];
        assign op_b[g] = req_b[32*g +: 32];
    end

    // first valid requester at or after last_grant+1, wrapping
    always_comb begin
        grant   = '0;
        gidx    = '0;
        idx     = '0;
        sum_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum_idx = {1'b0, last_grant} + (ID_W+1)'(k);
            idx     = (sum_idx >= NREQ) ? ID_W'(sum_idx - NREQ) : sum_idx[ID_W-1:0];
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gidx        = idx;
            end
        end
    end

    assign s2_load   = s1_valid & (~rsp_valid | rsp_ready);
    assign s1_free   = ~s1_valid | s2_load;
    assign req_ready = grant & {NUM_REQ{s1_free & rst_n}};
    assign hs        = |(req_valid & req_ready);
    assign busy      = s1_valid | rsp_valid;

    IEEE_754_subtractor u_sub (
        .a      (s1_a),
        .b      (s1_b),
        .result (sub_res),
        .valid  (sub_vld)
    );

    // stage 1: operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_id      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (s1_free) begin
            s1_valid <= hs;
            if (hs) begin
                s1_a       <= op_a[gidx];
                s1_b       <= op_b[gidx];
                s1_id      <= gidx;
                last_grant <= gidx;
            end
        end
    end

    // stage 2: response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flag   <= 1'b0;
        end else if (s2_load) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= s1_id;
            rsp_result <= sub_res;
            rsp_flag   <= sub_vld;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef FP_SUB_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy)
                perf_busy <= sat_inc(perf_busy);
            if (|req_valid & ~|req_ready)
                perf_stall <= sat_inc(perf_stall);
        end
    end
`endif
endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Directed bench for fp_sub_arbiter (NUM_REQ=4): scoreboard of expected responses
// pushed at each request handshake and popped at each response handshake.
module tb_fp_sub_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [32*N-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready, rsp_flag, busy;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_result;
`ifdef FP_SUB_ARB_PERF_EN
    logic [31:0]     perf_busy, perf_stall;
    logic [31:0]     p0;
`endif

    fp_sub_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .busy       (busy)
`ifdef FP_SUB_ARB_PERF_EN
        ,
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
`endif
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [31:0]   res;
    } exp_t;

    exp_t          sb_q[$];
    logic [31:0]   op_a [N][8];
    logic [31:0]   op_b [N][8];
    logic [31:0]   op_e [N][8];
    int            head [N];
    int            cnt  [N];
    int            total = 0;
    int            bad = 0;
    int            busy_seen = 0;
    int            hs_total;
    logic [N-1:0]  s_hs, s_ready;
    logic          s_rsp_valid, s_busy;
    logic [IW-1:0] s_id;
    logic [31:0]   s_res;
    logic [N-1:0]  rr_exp [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        op_a[r][cnt[r]] = a;
        op_b[r][cnt[r]] = b;
        op_e[r][cnt[r]] = e;
        cnt[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (head[i] < cnt[i]) begin
                req_valid[i]       = 1'b1;
                req_a[32*i +: 32]  = op_a[i][head[i]];
                req_b[32*i +: 32]  = op_b[i][head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_a[32*i +: 32]  = '0;
                req_b[32*i +: 32]  = '0;
            end
        end
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int i = 0; i < N; i++)
            if (head[i] < cnt[i]) p = 1'b1;
        return p;
    endfunction

    task automatic clear_ops();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        sb_q.delete();
        s_hs = '0;
        drive();
    endtask

    // sample at the falling edge, then advance drivers just after the rising edge
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        s_ready     = req_ready;
        s_hs        = req_valid & req_ready;
        s_rsp_valid = rsp_valid;
        s_id        = rsp_id;
        s_res       = rsp_result;
        s_busy      = busy;
        if (busy) busy_seen++;
        for (int i = 0; i < N; i++)
            if (s_hs[i]) sb_q.push_back('{id: IW'(i), res: op_e[i][head[i]]});
        if (rsp_valid && rsp_ready) begin
            total++;
            assert (sb_q.size() > 0) else begin
                bad++;
                $error("FAIL rsp_unexpected observed id=%0d result=%h expected=none", rsp_id, rsp_result);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_result", rsp_result, e.res);
                check("rsp_flag", 32'(rsp_flag), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (s_hs[i]) head[i]++;
        drive();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb_q.size() > 0 || pending() || busy) && n < 40) begin
            cycle();
            n++;
        end
        total++;
        assert (n < 40) else begin
            bad++;
            $error("FAIL %s_drain observed=%0d cycles expected=<40", tag, n);
        end
    endtask

    task automatic release_reset();
        clear_ops();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_seen = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_flag", 32'(rsp_flag), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        release_reset();

        // single request: 8 - 4
        add_op(0, 32'h4100_0000, 32'h4080_0000, 32'h4080_0000);
        drive();
        cycle();
        check("single_ready0", 32'(s_ready[0]), 32'd1);
        cycle();
        check("single_rsp_early", 32'(s_rsp_valid), 32'd0);
        check("single_busy", 32'(s_busy), 32'd1);
        cycle();
        check("single_rsp_valid", 32'(s_rsp_valid), 32'd1);
        check("single_rsp_id", 32'(s_id), 32'd0);
        check("single_rsp_result", s_res, 32'h4080_0000);
        drain("single");

        // zero and sign cases streamed by requester 3 alone
        add_op(3, 32'h3FC0_0000, 32'h3FC0_0000, 32'h0000_0000);
        add_op(3, 32'hC020_0000, 32'hC060_0000, 32'h3F80_0000);
        add_op(3, 32'h0000_0000, 32'h40A0_0000, 32'hC0A0_0000);
        drive();
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("solo_grant", 32'(s_hs), 32'b1000);
        end
        drain("zero_sign");

        // round robin: all four valid, requester 0 has a second operation
        add_op(0, 32'h4100_0000, 32'h4080_0000, 32'h4080_0000);
        add_op(0, 32'h40E0_0000, 32'h3F80_0000, 32'h40C0_0000);
        add_op(1, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
        add_op(2, 32'h40B0_0000, 32'h4020_0000, 32'h4040_0000);
        add_op(3, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000);
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;
        drive();
        for (int c = 0; c < 7; c++) begin
            cycle();
            if (c < 5) check("rr_grant", 32'(s_hs), 32'(rr_exp[c]));
            if (c >= 2) check("rr_rsp_every_cycle", 32'(s_rsp_valid), 32'd1);
        end
        drain("round_robin");

        // backpressure: requesters 1 and 3 stream while the consumer stalls
        rsp_ready = 1'b0;
        add_op(1, 32'h42C8_0000, 32'h41C8_0000, 32'h4296_0000);
        add_op(1, 32'h4100_0000, 32'h4080_0000, 32'h4080_0000);
        add_op(3, 32'h40B0_0000, 32'h4020_0000, 32'h4040_0000);
        drive();
`ifdef FP_SUB_ARB_PERF_EN
        p0 = perf_stall;
`endif
        hs_total = 0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            hs_total += $countones(s_hs);
            if (c >= 2) begin
                check("bp_req_ready", 32'(s_ready), 32'd0);
                check("bp_hold_valid", 32'(s_rsp_valid), 32'd1);
                check("bp_hold_id", 32'(s_id), 32'd1);
                check("bp_hold_result", s_res, 32'h4296_0000);
            end
        end
        check("bp_handshakes", 32'(hs_total), 32'd2);
`ifdef FP_SUB_ARB_PERF_EN
        check("perf_stall_delta", perf_stall - p0, 32'd3);
`endif
        rsp_ready = 1'b1;
        drain("backpressure");

        // reset with both stages full and a request still waiting
        rsp_ready = 1'b0;
        add_op(0, 32'h4100_0000, 32'h4080_0000, 32'h4080_0000);
        add_op(0, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
        add_op(2, 32'h40B0_0000, 32'h4020_0000, 32'h4040_0000);
        drive();
        cycle();
        cycle();
        cycle();
        check("mid_busy_before", 32'(s_busy), 32'd1);
        check("mid_rsp_valid_before", 32'(s_rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        release_reset();
        rsp_ready = 1'b1;
        add_op(2, 32'h40B0_0000, 32'h4020_0000, 32'h4040_0000);
        add_op(0, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000);
        drive();
        cycle();
        check("post_rst_priority", 32'(s_hs), 32'b0001);
        drain("post_reset");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef FP_SUB_ARB_PERF_EN
        check("perf_busy", perf_busy, 32'(busy_seen));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_sub_arbiter.md
# fp_sub_arbiter

Round-robin arbiter and two-stage pipeline that shares one combinational `IEEE_754_subtractor` instance among `NUM_REQ` requesters in the accelerator datapath, such as the error/gradient units of the output layer. It accepts operand pairs over per-requester valid/ready handshakes and registers the operands into the subtractor. It then registers the difference, tagged with the requester ID, onto a single response bus with backpressure.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..16. Derived localparam `ID_W = $clog2(NUM_REQ)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_a`  in  32*NUM_REQ  minuend for requester i, bits [32i+31:32i], IEEE-754 single precision.
- `req_b`  in  32*NUM_REQ  subtrahend for requester i, same packing.
- `req_ready`  out  NUM_REQ  one-hot or zero; acceptance strobe for requester i.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  requester index of the response.
- `rsp_result`  out  32  a − b.
- `rsp_flag`  out  1  subtractor `valid` output, captured with the result.
- `busy`  out  1  either pipeline stage is occupied.

## Operation
- **Stage 1, operand register.** Holds `s1_valid`, `s1_a`, `s1_b`, `s1_id`. The subtractor is driven from `s1_a` and `s1_b` only. Request-side operands never feed it directly.
- **Stage 2, response register.** Holds `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_flag`.
- **Advance rules.**
  - `s2_load = s1_valid & (~rsp_valid | rsp_ready)`.
  - `s1_free = ~s1_valid | s2_load`.
- **Arbitration.**
  - Arbitration is combinational over `req_valid`. Search starts at index `(last_grant+1) mod NUM_REQ` and takes the first valid requester.
  - `req_ready[i] = s1_free & grant[i]`.
  - On a handshake (`req_valid[i] & req_ready[i]`), stage 1 loads requester i's operands and `last_grant` becomes i.
- **Handshake rules.**
  - `req_ready` may depend combinationally on `req_valid`.
  - A requester must hold `req_valid`, `req_a` and `req_b` stable until its handshake.
  - `last_grant` changes only on a handshake, so a stalled grant never rotates away.
- **Response rules.**
  - The response is consumed when `rsp_valid & rsp_ready`.
  - While `rsp_valid` is high and `rsp_ready` is low, all response outputs hold stable.
- **Reset behaviour.**
  - All valids, data, `rsp_id` and `rsp_flag` reset to 0. `last_grant` resets to `NUM_REQ-1`, so requester 0 wins first.
  - Reset asserted mid-operation discards in-flight operations. No partial response appears after release.
- **Outputs.** `busy = s1_valid | rsp_valid`.

## Timing
- Latency is 2 cycles: a handshake at edge N gives `rsp_valid` high after edge N+1, with the result valid in the same cycle.
- Throughput is 1 result per cycle while `rsp_ready` is held high.
- With `rsp_ready` low, the pipeline absorbs 2 operations. `req_ready` is then all-zero until the response drains.
- Simultaneous consume and accept in one cycle: stage 2 takes stage 1 and stage 1 takes the new request. No bubble.
- A single requester asserting `req_valid` continuously is granted every cycle when the others are idle.

## Configuration
- `FP_SUB_ARB_PERF_EN` defined:
  - Adds output `perf_busy` [31:0], which counts cycles with `busy` high.
  - Adds output `perf_stall` [31:0], which counts cycles with `|req_valid & ~|req_ready`.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Not defined: the ports and counters are absent and the functional behaviour is identical.

## Test plan
- **Single request.** Requester 0 sends a=0x41000000, b=0x40800000. Expect `req_ready[0]` the same cycle, then 2 edges later `rsp_valid`=1, `rsp_id`=0, `rsp_result`=0x40800000.
- **Round-robin order.** All 4 requesters valid together with distinct operands (0x40B00000−0x40200000 on requester 2, expect 0x40400000). Expect grants in order 0,1,2,3, then 0, with responses in the same order and one per cycle.
- **Backpressure.** Hold `rsp_ready`=0 for 5 cycles while requesters 1 and 3 stream. Expect exactly 2 handshakes, then `req_ready`=0. Expect outputs stable, and on release no loss or duplication; the 0x42C80000−0x41C80000 response reads 0x42960000.
- **Zero and sign cases.** 0x3FC00000−0x3FC00000 gives 0x00000000. 0xC0200000−0xC0600000 gives 0x3F800000. 0x00000000−0x40A00000 gives 0xC0A00000.
- **Reset mid-flight.** Assert `rst_n`=0 with both stages full. Expect `rsp_valid`, `busy` and `req_ready` at 0 immediately. After release, requester 0 has priority.
- **Perf counters** (`FP_SUB_ARB_PERF_EN`). The backpressure scenario yields `perf_stall`=3 and a `perf_busy` count equal to the observed busy cycles.
